// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback
// requesters, plus a pending-write scoreboard for read-after-write hazard checks.
module regfile_wb_arbiter #(
  parameter int REG_WORD_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REQ        = 2
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [NUM_REQ-1:0]                 REQ_VALID_i,
  output logic [NUM_REQ-1:0]                 REQ_READY_o,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  REQ_ADDR_i,
  input  logic [NUM_REQ*REG_WORD_WIDTH-1:0]  REQ_DATA_i,
  input  logic                               RESERVE_EN_i,
  input  logic [REG_ADDR_WIDTH-1:0]          RESERVE_REG_i,
  input  logic [REG_ADDR_WIDTH-1:0]          CHECK_REG1_i,
  input  logic [REG_ADDR_WIDTH-1:0]          CHECK_REG2_i,
  output logic                               BUSY1_o,
  output logic                               BUSY2_o,
  output logic                               WRITE_EN_o,
  output logic [REG_ADDR_WIDTH-1:0]          WRITE_REG_o,
  output logic [REG_WORD_WIDTH-1:0]          WRITE_DATA_o
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int NUM_RF = 1 << REG_ADDR_WIDTH;

  logic [PTR_W-1:0]          ptr;
  logic [PTR_W-1:0]          ptr_next;
  logic [PTR_W-1:0]          grant_idx;
  logic                      grant_vld;
  logic [REG_ADDR_WIDTH-1:0] grant_addr;
  logic [REG_WORD_WIDTH-1:0] grant_data;
  logic [NUM_RF-1:0]         busy;
  logic [NUM_RF-1:0]         busy_next;

  // Scan from the pointer, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    REQ_READY_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && REQ_VALID_i[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (!RST_N) grant_vld = 1'b0;
    if (grant_vld) REQ_READY_o[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_addr = '0;
    grant_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        grant_addr = REQ_ADDR_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        grant_data = REQ_DATA_i[k*REG_WORD_WIDTH +: REG_WORD_WIDTH];
      end
    end
  end

  always_comb begin
    if (grant_idx == PTR_W'(NUM_REQ - 1)) ptr_next = '0;
    else                                  ptr_next = grant_idx + 1'b1;
  end

  // Clear on commit first, then set, so a same-cycle reservation wins.
  always_comb begin
    busy_next = busy;
    if (WRITE_EN_o) busy_next[WRITE_REG_o] = 1'b0;
    if (RESERVE_EN_i && (RESERVE_REG_i != '0)) busy_next[RESERVE_REG_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr          <= '0;
      busy         <= '0;
      WRITE_EN_o   <= 1'b0;
      WRITE_REG_o  <= '0;
      WRITE_DATA_o <= '0;
    end else begin
      busy <= busy_next;
      if (grant_vld) begin
        ptr <= ptr_next;
        // Writes to register 0 complete the handshake but never reach the file.
        if (grant_addr != '0) begin
          WRITE_EN_o   <= 1'b1;
          WRITE_REG_o  <= grant_addr;
          WRITE_DATA_o <= grant_data;
        end else begin
          WRITE_EN_o <= 1'b0;
        end
      end else begin
        WRITE_EN_o <= 1'b0;
      end
    end
  end

  assign BUSY1_o = (CHECK_REG1_i != '0) && busy[CHECK_REG1_i];
  assign BUSY2_o = (CHECK_REG2_i != '0) && busy[CHECK_REG2_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write latency,
// register-0 drop, scoreboard set/clear and reset behaviour.
module tb_regfile_wb_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        reserve_en;
  logic [4:0]  reserve_reg;
  logic [4:0]  check_reg1;
  logic [4:0]  check_reg2;
  logic        busy1;
  logic        busy2;
  logic        write_en;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(
    .REG_WORD_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .NUM_REQ(2)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .REQ_VALID_i(req_valid),
    .REQ_READY_o(req_ready),
    .REQ_ADDR_i(req_addr),
    .REQ_DATA_i(req_data),
    .RESERVE_EN_i(reserve_en),
    .RESERVE_REG_i(reserve_reg),
    .CHECK_REG1_i(check_reg1),
    .CHECK_REG2_i(check_reg2),
    .BUSY1_o(busy1),
    .BUSY2_o(busy2),
    .WRITE_EN_o(write_en),
    .WRITE_REG_o(write_reg),
    .WRITE_DATA_o(write_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST_N       = 1'b0;
    req_valid   = 2'b11;
    req_addr    = '0;
    req_data    = '0;
    reserve_en  = 1'b0;
    reserve_reg = '0;
    check_reg1  = 5'd7;
    check_reg2  = 5'd7;
    step();
    step();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wen", 32'(write_en), 32'h0);
    check("rst_wreg", 32'(write_reg), 32'h0);
    check("rst_wdata", write_data, 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);

    RST_N     = 1'b1;
    req_valid = 2'b00;
    step();

    // single request from requester 1
    req_valid       = 2'b10;
    req_addr[9:5]   = 5'd5;
    req_data[63:32] = 32'hDEADBEEF;
    settle();
    check("t1_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    check("t1_wen", 32'(write_en), 32'h1);
    check("t1_wreg", 32'(write_reg), 32'd5);
    check("t1_wdata", write_data, 32'hDEADBEEF);
    step();
    check("t1_wen_off", 32'(write_en), 32'h0);
    check("t1_wreg_hold", 32'(write_reg), 32'd5);

    // both valid: grants alternate 0,1,0,1
    req_valid       = 2'b11;
    req_addr        = {5'd4, 5'd3};
    req_data        = {32'hB1B1B1B1, 32'hA0A0A0A0};
    settle();
    for (int i = 0; i < 4; i++) begin
      check("t2_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check("t2_wen", 32'(write_en), 32'h1);
      check("t2_wdata", write_data, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      check("t2_wreg", 32'(write_reg), (i % 2 == 0) ? 32'd3 : 32'd4);
    end
    req_valid = 2'b00;
    step();
    check("t2_wen_off", 32'(write_en), 32'h0);

    // write to register 0: accepted, dropped, pointer advances
    req_valid      = 2'b01;
    req_addr[4:0]  = 5'd0;
    req_data[31:0] = 32'h1234;
    settle();
    check("t3_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    check("t3_wen", 32'(write_en), 32'h0);
    req_addr  = {5'd4, 5'd3};
    req_valid = 2'b11;
    settle();
    check("t3_ptr", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    step();

    // scoreboard reserve / clear
    reserve_en  = 1'b1;
    reserve_reg = 5'd7;
    check_reg1  = 5'd7;
    settle();
    check("t4_busy_pre", 32'(busy1), 32'h0);
    step();
    reserve_en = 1'b0;
    check("t4_busy_set", 32'(busy1), 32'h1);
    req_valid      = 2'b01;
    req_addr[4:0]  = 5'd7;
    req_data[31:0] = 32'h77;
    settle();
    check("t4_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    check("t4_wen", 32'(write_en), 32'h1);
    check("t4_wreg", 32'(write_reg), 32'd7);
    check("t4_busy_n1", 32'(busy1), 32'h1);
    step();
    check("t4_busy_n2", 32'(busy1), 32'h0);

    // reservation in the commit cycle wins
    req_valid = 2'b01;
    step();
    req_valid   = 2'b00;
    reserve_en  = 1'b1;
    reserve_reg = 5'd7;
    check("t4b_wen", 32'(write_en), 32'h1);
    step();
    reserve_en = 1'b0;
    check("t4b_busy", 32'(busy1), 32'h1);
    step();
    check("t4b_busy_hold", 32'(busy1), 32'h1);

    // register 0 is never busy
    reserve_en  = 1'b1;
    reserve_reg = 5'd0;
    check_reg2  = 5'd0;
    step();
    step();
    reserve_en = 1'b0;
    check("t5_busy2_r0", 32'(busy2), 32'h0);
    check_reg2 = 5'd7;
    settle();
    check("t5_busy2_r7", 32'(busy2), 32'h1);

    // reset right after an accepted write
    req_valid       = 2'b10;
    req_addr[9:5]   = 5'd9;
    req_data[63:32] = 32'h99;
    step();
    check("t6_wen_pre", 32'(write_en), 32'h1);
    RST_N     = 1'b0;
    req_valid = 2'b11;
    settle();
    check("t6_ready_rst", 32'(req_ready), 32'h0);
    step();
    check("t6_wen", 32'(write_en), 32'h0);
    check("t6_wreg", 32'(write_reg), 32'h0);
    check("t6_busy1", 32'(busy1), 32'h0);
    check("t6_busy2", 32'(busy2), 32'h0);
    RST_N = 1'b1;
    settle();
    check("t6_prio", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port among NUM_REQ writeback requesters (e.g. ALU, load unit, multiply unit) using round-robin arbitration and a valid/ready handshake. The winning write is registered and driven onto the register file's write port one cycle later. The block also keeps a pending-write scoreboard, so the issue logic can detect read-after-write hazards on the two read ports.

Parameters:
- REG_WORD_WIDTH, 32, data word width; must match the register file.
- REG_ADDR_WIDTH, 5, register address width; there are 2^REG_ADDR_WIDTH registers.
- NUM_REQ, 2, number of writeback requesters; legal range is 2 to 4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- REQ_VALID_i  in  NUM_REQ  per-requester write request valid.
- REQ_READY_o  out  NUM_REQ  per-requester grant; combinational from REQ_VALID_i and the priority pointer.
- REQ_ADDR_i  in  NUM_REQ*REG_ADDR_WIDTH  destination register; requester k occupies slice k.
- REQ_DATA_i  in  NUM_REQ*REG_WORD_WIDTH  write data; requester k occupies slice k.
- RESERVE_EN_i  in  1  issue logic marks a destination register as pending.
- RESERVE_REG_i  in  REG_ADDR_WIDTH  register to mark pending.
- CHECK_REG1_i  in  REG_ADDR_WIDTH  hazard query 1.
- CHECK_REG2_i  in  REG_ADDR_WIDTH  hazard query 2.
- BUSY1_o  out  1  CHECK_REG1_i has a pending write; combinational.
- BUSY2_o  out  1  CHECK_REG2_i has a pending write; combinational.
- WRITE_EN_o  out  1  register file write enable; registered.
- WRITE_REG_o  out  REG_ADDR_WIDTH  register file write address; registered.
- WRITE_DATA_o  out  REG_WORD_WIDTH  register file write data; registered.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - Priority pointer goes to 0, so requester 0 has highest priority.
  - All busy bits clear.
  - WRITE_EN_o, WRITE_REG_o and WRITE_DATA_o go to 0.
  - Reset asserted mid-transfer discards the registered write: WRITE_EN_o is 0 in the following cycle.
  - REQ_READY_o is all-zero while RST_N=0.
- Arbitration:
  - Requesters are scanned starting at the pointer index and wrapping modulo NUM_REQ.
  - The first requester with REQ_VALID_i=1 receives REQ_READY_o=1; all others get 0.
  - At most one grant is issued per cycle.
  - A transfer is REQ_VALID_i & REQ_READY_o in the same cycle.
- Pointer update: after a transfer by requester k, the pointer becomes (k+1) mod NUM_REQ. With no transfer, the pointer holds.
- Latency:
  - A request accepted in cycle n appears on WRITE_EN_o/WRITE_REG_o/WRITE_DATA_o in cycle n+1, for exactly one cycle.
  - The register file commits the write at the end of cycle n+1.
  - With no transfer, WRITE_EN_o is 0 in the next cycle; WRITE_REG_o and WRITE_DATA_o hold their previous values.
- Back-to-back: a write is accepted every cycle while any requester is valid. There is no backpressure from the register file.
- Register 0:
  - A request to address 0 is accepted (handshake completes and the pointer advances).
  - The write is dropped: WRITE_EN_o stays 0.
- Scoreboard:
  - One busy bit per register 1 to 2^REG_ADDR_WIDTH-1; register 0 is never busy.
  - RESERVE_EN_i=1 with a nonzero RESERVE_REG_i sets that bit at the edge.
  - WRITE_EN_o=1 clears the bit for WRITE_REG_o at the same edge the register file commits.
  - If set and clear target the same register in the same cycle, set wins (the newer reservation).
  - BUSY1_o = busy[CHECK_REG1_i] and BUSY2_o = busy[CHECK_REG2_i], both forced to 0 for address 0.
  - A write to a register that is not busy is legal and leaves its bit at 0.
- Requester rules:
  - Once a requester raises REQ_VALID_i, it holds VALID, ADDR and DATA stable until its transfer completes.
  - The arbiter does not rely on this; a dropped request is simply not granted.

Test Plan:
- Reset, then only requester 1 valid with addr=5, data=0xDEADBEEF → REQ_READY_o=2'b10 in the same cycle; next cycle WRITE_EN_o=1, WRITE_REG_o=5, WRITE_DATA_o=0xDEADBEEF; the cycle after that WRITE_EN_o=0.
- NUM_REQ=2, both requesters valid continuously for 4 cycles → grants in order 0,1,0,1; WRITE_EN_o=1 for 4 consecutive cycles, one cycle delayed, with data alternating to match.
- Requester 0 valid with addr=0, data=0x1234 → handshake completes and the pointer moves to 1; WRITE_EN_o stays 0.
- Reserve reg 7, then CHECK_REG1_i=7 → BUSY1_o=1 from the next cycle. A write to 7 is accepted in cycle n; BUSY1_o=0 from cycle n+2. Reserve 7 in the same cycle as WRITE_EN_o for reg 7 → BUSY1_o stays 1.
- RESERVE_REG_i=0 and CHECK_REG2_i=0 → BUSY2_o=0 always.
- Accept a write, then assert RST_N=0 in the following cycle → WRITE_EN_o=0, all busy bits cleared, REQ_READY_o=0; after release, requester 0 has priority.
